// File: rtl/bit_pack_pkg.sv
// Shared constants and the field mask helper for the bit packer.
package bit_pack_pkg;
   localparam int WORD_W  = 32;
   localparam int LEN_W   = 4;
   localparam int FIELD_W = 15;
   localparam int ACC_W   = WORD_W + FIELD_W;
   localparam int CNT_W   = 6;

   // Low 'len' bits set; computed one bit wider so len=15 yields 0x7FFF.
   function automatic logic [FIELD_W-1:0] field_mask(input logic [LEN_W-1:0] len);
      logic [FIELD_W:0] m;
      m = ({{FIELD_W{1'b0}}, 1'b1} << len) - {{FIELD_W{1'b0}}, 1'b1};
      return m[FIELD_W-1:0];
   endfunction
endpackage

// File: rtl/bit_pack_merge.sv
// Combinational merge of one masked field into the accumulator above the
// current valid bits.
module bit_pack_merge
   import bit_pack_pkg::*;
(
   input  logic [46:0] acc,
   input  logic [5:0]  cnt,
   input  logic [14:0] field,
   input  logic [3:0]  len,
   output logic [46:0] acc_next,
   output logic [5:0]  cnt_next
);
   logic [ACC_W-1:0] ext;

   always_comb begin
      ext      = {{(ACC_W-FIELD_W){1'b0}}, field & field_mask(len)};
      acc_next = acc | (ext << cnt);
      cnt_next = cnt + {2'b00, len};
   end
endmodule

// File: rtl/bit_pack.sv
// LSB-first bit packer: 0..15-bit fields in, 32-bit words out, flush drains the tail.
// Optional BIT_PACK_STATS_EN adds wordcnt/dropcnt statistics outputs.
module bit_pack
   import bit_pack_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        pushin,
   input  logic [3:0]  lenin,
   input  logic [14:0] datain,
   input  logic        flush,
   output logic        ready,
   output logic        pushout,
   output logic [31:0] dataout,
   output logic [5:0]  bitsout
`ifdef BIT_PACK_STATS_EN
   ,
   output logic [15:0] wordcnt,
   output logic [7:0]  dropcnt
`endif
);
   logic [ACC_W-1:0] acc, acc_next;
   logic [CNT_W-1:0] cnt, cnt_next;
   logic             flush_pend;
   logic             accept;
   logic [LEN_W-1:0] eff_len;
   logic             emit_now;

   // ready is only withdrawn while the second half of a split flush is pending.
   assign ready    = ~flush_pend;
   assign accept   = pushin & ready;
   assign eff_len  = accept ? lenin : '0;
   assign emit_now = flush_pend | (flush & (cnt_next != '0)) | (cnt_next >= 6'd32);

   bit_pack_merge u_merge (
      .acc      (acc),
      .cnt      (cnt),
      .field    (datain),
      .len      (eff_len),
      .acc_next (acc_next),
      .cnt_next (cnt_next)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         acc        <= '0;
         cnt        <= '0;
         flush_pend <= 1'b0;
         pushout    <= 1'b0;
         dataout    <= '0;
         bitsout    <= '0;
      end else begin
         pushout <= 1'b0;
         bitsout <= '0;
         if (flush_pend) begin
            // Bits above cnt are always zero, so the tail is already padded.
            pushout    <= 1'b1;
            dataout    <= acc[WORD_W-1:0];
            bitsout    <= cnt;
            acc        <= '0;
            cnt        <= '0;
            flush_pend <= 1'b0;
         end else if (flush && cnt_next != '0) begin
            pushout <= 1'b1;
            dataout <= acc_next[WORD_W-1:0];
            if (cnt_next > 6'd32) begin
               bitsout    <= 6'd32;
               acc        <= acc_next >> WORD_W;
               cnt        <= cnt_next - 6'd32;
               flush_pend <= 1'b1;
            end else begin
               bitsout <= cnt_next;
               acc     <= '0;
               cnt     <= '0;
            end
         end else if (cnt_next >= 6'd32) begin
            pushout <= 1'b1;
            dataout <= acc_next[WORD_W-1:0];
            bitsout <= 6'd32;
            acc     <= acc_next >> WORD_W;
            cnt     <= cnt_next - 6'd32;
         end else begin
            acc <= acc_next;
            cnt <= cnt_next;
         end
      end
   end

`ifdef BIT_PACK_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         wordcnt <= '0;
         dropcnt <= '0;
      end else begin
         if (emit_now)
            wordcnt <= wordcnt + 16'd1;
         if (pushin && !ready && dropcnt != 8'hFF)
            dropcnt <= dropcnt + 8'd1;
      end
   end
`endif
endmodule
